adc_seq: RTL and testbench
==========================

# adc_seq

Command sequencer directly upstream of the SPI master that talks to the ADC. After `start`, it writes a fixed set of 32-bit configuration words to the ADC through the master. It then issues periodic 32-bit read transfers and presents the low 16 bits of each result as a sample with a one-cycle valid strobe to the downstream converter logic. It owns all `writ_flag`/`read_flag` generation and enforces one outstanding transfer at a time, with a timeout.

## Interface
Parameters:
- `CFG_WORDS`, 4: number of configuration words written after `start` (1..16).
- `SAMPLE_GAP`, 1000: idle clock cycles between end of one read and the next `read_flag` (≥1).
- `TIMEOUT`, 64: clock cycles allowed from flag to `xfer_done` before error (> 33).

Ports:
- `clk`  in  1  single system clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; begins config then sampling; ignored unless in IDLE or ERR.
- `stop`  in  1  one-cycle pulse; ends sampling after any in-flight transfer.
- `writ_flag`  out  1  one-cycle pulse to SPI master: start write of `writ_data`.
- `writ_data`  out  32  config word; stable from `writ_flag` until `xfer_done`.
- `read_flag`  out  1  one-cycle pulse to SPI master: start 32-bit read.
- `xfer_done`  in  1  one-cycle pulse from master at end of any transfer.
- `read_data`  in  32  master read result; valid in the `xfer_done` cycle of a read.
- `sample_data`  out  16  captured `read_data[15:0]`; holds until next sample.
- `sample_valid`  out  1  one-cycle pulse, coincident with new `sample_data`.
- `cfg_done`  out  1  level; high once all config words are acknowledged; cleared by `start`.
- `busy`  out  1  high in every state except IDLE and ERR.
- `err`  out  1  sticky timeout flag; cleared by next accepted `start`.

## Operation
- States: IDLE, CFG_ISSUE, CFG_WAIT, GAP, RD_ISSUE, RD_WAIT, ERR.
- IDLE/ERR + `start` → CFG_ISSUE. Clear word index, `cfg_done`, `err`.
- CFG_ISSUE: assert `writ_flag` for one cycle with `writ_data` = `cfg_word(index)`, then go to CFG_WAIT.
- CFG_WAIT + `xfer_done`:
  - If index = `CFG_WORDS`-1, set `cfg_done` and go to GAP.
  - Otherwise increment index and go to CFG_ISSUE.
- GAP: count `SAMPLE_GAP` cycles, then go to RD_ISSUE. `stop` → IDLE immediately.
- RD_ISSUE: assert `read_flag` for one cycle, then go to RD_WAIT.
- RD_WAIT + `xfer_done`: capture `read_data[15:0]` and pulse `sample_valid` next cycle. Go to GAP, or to IDLE if a stop is pending.
- `stop` during CFG_*/RD_* is latched as stop-pending. The current transfer completes, including its sample, then the block enters IDLE. Config is not resumed.
- Timeout counter is reset by each flag and runs in CFG_WAIT/RD_WAIT. Reaching `TIMEOUT` → ERR and `err`=1; no flag is issued.
- `xfer_done` outside CFG_WAIT/RD_WAIT is ignored.
- `start` while busy is ignored. `start` and `stop` in the same IDLE cycle: `start` wins, stop is discarded.
- `stop` and `xfer_done` in the same RD_WAIT cycle: sample is emitted, then IDLE.
- `xfer_done` in the same cycle that the timeout is reached: `xfer_done` wins; no error.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0, stop-pending 0.
- Flags are registered. `writ_flag`/`read_flag` assert the cycle after entering the issue state and last exactly one cycle.
- `start` accepted at edge N → `writ_flag` high in cycle N+2.
- `xfer_done` at edge M in RD_WAIT → `sample_valid` and `sample_data` update at edge M+1.
- Read period = transfer time + `SAMPLE_GAP` + 2 cycles.
- Reset mid-transfer aborts immediately; the master is reset by the same `rst_n`.

## Structure
- Package `adc_pkg`: state enum, `CFG_WORDS` maximum (16), default config word constants, sample width (16).
- Sub-module `adc_cfg_rom`: combinational index → 32-bit config word lookup, contents from `adc_pkg`.
- Top holds the FSM, gap/timeout counters and sample register.

## Test plan
- Reset → all outputs 0, `busy`=0.
- `start`, with a master model answering `xfer_done` 33 cycles after each flag:
  - Expect 4 `writ_flag` pulses carrying the ROM words in order.
  - Expect `cfg_done`=1 after the 4th `xfer_done`.
  - Then expect `read_flag` 1002 cycles later.
- Model returns `read_data`=32'hABCD_1234 → `sample_data`=16'h1234 with a one-cycle `sample_valid`. Repeat with 16'hFFFF and 16'h0000.
- `stop` in the same cycle as a read's `xfer_done` → sample emitted, state IDLE, no further flags.
- Model never returns `xfer_done` on the 2nd config word → `err`=1 exactly 64 cycles after the flag, `busy`=0. A later `start` clears `err` and reconfigures from word 0.
- `start` pulses during CFG_WAIT and RD_WAIT, plus spurious `xfer_done` in GAP → no extra flags, no state change.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC command sequencer:
// FSM states, sample width and the default ADC configuration image.
package adc_pkg;

  localparam int CFG_WORDS_MAX = 16;
  localparam int SAMPLE_W      = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CFG_ISSUE = 3'd1,
    ST_CFG_WAIT  = 3'd2,
    ST_GAP       = 3'd3,
    ST_RD_ISSUE  = 3'd4,
    ST_RD_WAIT   = 3'd5,
    ST_ERR       = 3'd6
  } adc_state_e;

  // Index 0 is written first: soft reset, then mode, channel and rate setup.
  localparam logic [0:CFG_WORDS_MAX-1][31:0] CFG_ROM = {
    32'h8000_0001, 32'h4100_00A5, 32'h4200_1F3C, 32'h4300_7E01,
    32'h4400_0000, 32'h4500_0000, 32'h4600_0000, 32'h4700_0000,
    32'h4800_0000, 32'h4900_0000, 32'h4A00_0000, 32'h4B00_0000,
    32'h4C00_0000, 32'h4D00_0000, 32'h4E00_0000, 32'h4F00_0000
  };

endpackage

// File: rtl/adc_seq_if.sv
// Command/response bundle between the sequencer (master modport)
// and the SPI master engine (slave modport).
interface adc_seq_if;

  logic        writ_flag;
  logic [31:0] writ_data;
  logic        read_flag;
  logic        xfer_done;
  logic [31:0] read_data;

  modport master (
    output writ_flag,
    output writ_data,
    output read_flag,
    input  xfer_done,
    input  read_data
  );

  modport slave (
    input  writ_flag,
    input  writ_data,
    input  read_flag,
    output xfer_done,
    output read_data
  );

endinterface

// File: rtl/adc_cfg_rom.sv
// Combinational lookup of the configuration word for a given index.
module adc_cfg_rom
  import adc_pkg::*;
(
  input  logic [3:0]  i_idx,
  output logic [31:0] o_word
);

  // Pure table lookup; every 4-bit index maps to a defined entry.
  always_comb begin
    o_word = CFG_ROM[i_idx];
  end

endmodule

// File: rtl/adc_seq.sv
// ADC command sequencer: writes the configuration image, then issues
// periodic reads and emits 16-bit samples, one transfer in flight at a time.
module adc_seq
  import adc_pkg::*;
#(
  parameter int CFG_WORDS  = 4,
  parameter int SAMPLE_GAP = 1000,
  parameter int TIMEOUT    = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic                i_stop,
  adc_seq_if.master           spi,
  output logic [SAMPLE_W-1:0] o_sample_data,
  output logic                o_sample_valid,
  output logic                o_cfg_done,
  output logic                o_busy,
  output logic                o_err
);

  localparam int            TW       = $clog2(TIMEOUT);
  localparam int            GW       = $clog2(SAMPLE_GAP + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(SAMPLE_GAP);
  localparam logic [3:0]    IDX_LAST = 4'(CFG_WORDS - 1);

  adc_state_e          r_state;
  adc_state_e          w_next;
  logic [3:0]          r_idx;
  logic [TW-1:0]       r_tmo;
  logic [GW-1:0]       r_gap;
  logic                r_stop_pend;
  logic                r_writ_flag;
  logic                r_read_flag;
  logic [31:0]         r_writ_data;
  logic                r_cap;
  logic [SAMPLE_W-1:0] r_rd_hold;
  logic [SAMPLE_W-1:0] r_sample_data;
  logic                r_sample_valid;
  logic                r_cfg_done;
  logic                r_busy;
  logic                r_err;
  logic [31:0]         w_rom_word;
  logic                w_start_ok;
  logic                w_stop_any;
  logic                w_tmo_hit;
  logic                w_cfg_last;
  logic                w_in_xfer;
  logic                w_done_cfg;
  logic                w_done_rd;

  assign w_start_ok = i_start & ((r_state == ST_IDLE) | (r_state == ST_ERR));
  assign w_stop_any = i_stop | r_stop_pend;
  assign w_tmo_hit  = (r_tmo == TMO_LAST);
  assign w_cfg_last = (r_idx == IDX_LAST);
  assign w_in_xfer  = (r_state == ST_CFG_ISSUE) | (r_state == ST_CFG_WAIT) |
                      (r_state == ST_RD_ISSUE)  | (r_state == ST_RD_WAIT);
  assign w_done_cfg = (r_state == ST_CFG_WAIT) & spi.xfer_done;
  assign w_done_rd  = (r_state == ST_RD_WAIT) & spi.xfer_done;

  adc_cfg_rom u_rom (
    .i_idx  (r_idx),
    .o_word (w_rom_word)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; a completion beats a same-cycle timeout.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_ERR: begin
        if (i_start) w_next = ST_CFG_ISSUE;
        else         w_next = r_state;
      end
      ST_CFG_ISSUE: w_next = ST_CFG_WAIT;
      ST_CFG_WAIT: begin
        if (spi.xfer_done) begin
          if (w_stop_any)      w_next = ST_IDLE;
          else if (w_cfg_last) w_next = ST_GAP;
          else                 w_next = ST_CFG_ISSUE;
        end else if (w_tmo_hit) w_next = ST_ERR;
        else                    w_next = r_state;
      end
      ST_GAP: begin
        if (i_stop)                 w_next = ST_IDLE;
        else if (r_gap == GAP_LAST) w_next = ST_RD_ISSUE;
        else                        w_next = r_state;
      end
      ST_RD_ISSUE: w_next = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (spi.xfer_done) begin
          if (w_stop_any) w_next = ST_IDLE;
          else            w_next = ST_GAP;
        end else if (w_tmo_hit) w_next = ST_ERR;
        else                    w_next = r_state;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Transfer-side registers: flags, write word, watchdog and gap counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_writ_flag <= 1'b0;
      r_read_flag <= 1'b0;
      r_writ_data <= 32'd0;
      r_tmo       <= '0;
      r_gap       <= '0;
      r_idx       <= 4'd0;
    end else begin
      r_writ_flag <= (r_state == ST_CFG_ISSUE);
      r_read_flag <= (r_state == ST_RD_ISSUE);
      if (r_state == ST_CFG_ISSUE) r_writ_data <= w_rom_word;
      else                         r_writ_data <= r_writ_data;
      if ((r_state == ST_CFG_WAIT) || (r_state == ST_RD_WAIT)) r_tmo <= r_tmo + TW'(1);
      else                                                      r_tmo <= '0;
      if (r_state == ST_GAP) r_gap <= r_gap + GW'(1);
      else                   r_gap <= '0;
      if (w_start_ok)                    r_idx <= 4'd0;
      else if (w_done_cfg && !w_cfg_last) r_idx <= r_idx + 4'd1;
      else                               r_idx <= r_idx;
    end
  end

  // Status and sample path; the sample lands one cycle after the read completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stop_pend    <= 1'b0;
      r_cap          <= 1'b0;
      r_rd_hold      <= '0;
      r_sample_data  <= '0;
      r_sample_valid <= 1'b0;
      r_cfg_done     <= 1'b0;
      r_busy         <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      if (w_start_ok || (w_next == ST_IDLE) || (w_next == ST_ERR)) r_stop_pend <= 1'b0;
      else if (i_stop && w_in_xfer)                                  r_stop_pend <= 1'b1;
      else                                                           r_stop_pend <= r_stop_pend;
      r_cap          <= w_done_rd;
      r_sample_valid <= r_cap;
      if (w_done_rd) r_rd_hold <= spi.read_data[SAMPLE_W-1:0];
      else           r_rd_hold <= r_rd_hold;
      if (r_cap) r_sample_data <= r_rd_hold;
      else       r_sample_data <= r_sample_data;
      if (w_start_ok)                    r_cfg_done <= 1'b0;
      else if (w_done_cfg && w_cfg_last) r_cfg_done <= 1'b1;
      else                               r_cfg_done <= r_cfg_done;
      if (w_start_ok)                                     r_err <= 1'b0;
      else if ((w_next == ST_ERR) && (r_state != ST_ERR)) r_err <= 1'b1;
      else                                                r_err <= r_err;
      r_busy <= (w_next != ST_IDLE) && (w_next != ST_ERR);
    end
  end

  assign spi.writ_flag  = r_writ_flag;
  assign spi.writ_data  = r_writ_data;
  assign spi.read_flag  = r_read_flag;
  assign o_sample_data  = r_sample_data;
  assign o_sample_valid = r_sample_valid;
  assign o_cfg_done     = r_cfg_done;
  assign o_busy         = r_busy;
  assign o_err          = r_err;

endmodule

// File: tb/tb_adc_seq.sv
// Bench for adc_seq: SPI master responder plus an expectation model that
// predicts when each flag, sample and status change must appear.
module tb_adc_seq;

  localparam int CFG_WORDS  = 4;
  localparam int SAMPLE_GAP = 1000;
  localparam int TIMEOUT    = 64;
  localparam int XFER_LAT   = 33;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic [15:0] sample_data;
  logic        sample_valid;
  logic        cfg_done;
  logic        busy;
  logic        err;

  adc_seq_if bus ();

  adc_seq #(
    .CFG_WORDS  (CFG_WORDS),
    .SAMPLE_GAP (SAMPLE_GAP),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_start        (start),
    .i_stop         (stop),
    .spi            (bus),
    .o_sample_data  (sample_data),
    .o_sample_valid (sample_valid),
    .o_cfg_done     (cfg_done),
    .o_busy         (busy),
    .o_err          (err)
  );

  always #5 clk = ~clk;

  logic [31:0] cfg_tab [CFG_WORDS] = '{32'h8000_0001, 32'h4100_00A5, 32'h4200_1F3C, 32'h4300_7E01};

  int n_pass = 0, n_chk = 0, n_fail = 0, cyc = 0;
  int exp_flag_tick = -1, exp_flag_kind = 0;
  int exp_err_tick = -1, exp_cfg_tick = -10, exp_clr_tick = -10;
  int widx = 0, drop_at = -1, m_cnt = 0, m_kind = 0, n_reads = 0, n_samples = 0;
  bit m_busy = 1'b0, req_start = 1'b0, req_stop = 1'b0, req_spur = 1'b0, stop_with_done = 1'b0;
  logic [31:0] m_data = 32'd0, m_word = 32'd0;
  logic [31:0] force_q [$];
  logic [15:0] exp_sd_q [$];
  int          exp_st_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  // One clock: observe outputs at the falling edge, update the model, drive inputs.
  task automatic tick();
    logic [31:0] r;
    logic [15:0] e_sd;
    int          e_st;
    @(negedge clk);
    cyc++;
    if (bus.writ_flag === 1'b1 || bus.read_flag === 1'b1) begin
      chk("flag_excl", 32'(bus.writ_flag & bus.read_flag), 32'd0);
      chk("flag_tick", 32'(cyc), 32'(exp_flag_tick));
      chk("flag_kind", 32'(bus.read_flag), 32'(exp_flag_kind));
      exp_flag_tick = -1;
      if (bus.writ_flag === 1'b1) begin
        chk("writ_data", bus.writ_data, (widx < CFG_WORDS) ? cfg_tab[widx] : 32'hDEAD_BEEF);
        m_kind = 0;
        m_word = bus.writ_data;
        if (widx == drop_at) begin
          m_cnt        = 0;
          exp_err_tick = cyc + TIMEOUT;
          drop_at      = -1;
        end else m_cnt = XFER_LAT;
      end else begin
        m_kind = 1;
        m_cnt  = XFER_LAT;
        if (force_q.size() > 0) m_data = force_q.pop_front();
        else                    m_data = $urandom;
      end
    end
    if (sample_valid === 1'b1) begin
      n_samples++;
      if (exp_sd_q.size() > 0) begin
        e_sd = exp_sd_q.pop_front();
        e_st = exp_st_q.pop_front();
        chk("sample_data", 32'(sample_data), 32'(e_sd));
        chk("sample_tick", 32'(cyc), 32'(e_st));
      end else chk("unexpected_sample", 32'd1, 32'd0);
    end
    if (exp_err_tick > 0 && cyc == exp_err_tick - 1) chk("err_before_timeout", 32'(err), 32'd0);
    if (exp_err_tick > 0 && cyc == exp_err_tick) begin
      chk("err_at_timeout", 32'(err), 32'd1);
      chk("busy_at_timeout", 32'(busy), 32'd0);
      m_busy = 1'b0;
    end
    if (cyc == exp_cfg_tick - 1) chk("cfg_done_early", 32'(cfg_done), 32'd0);
    if (cyc == exp_cfg_tick)     chk("cfg_done_set", 32'(cfg_done), 32'd1);
    if (cyc == exp_clr_tick) begin
      chk("err_cleared", 32'(err), 32'd0);
      chk("cfg_done_cleared", 32'(cfg_done), 32'd0);
      chk("busy_after_start", 32'(busy), 32'd1);
    end
    start         = 1'b0;
    stop          = 1'b0;
    bus.xfer_done = 1'b0;
    if (req_start) begin
      start     = 1'b1;
      req_start = 1'b0;
      if (!m_busy) begin
        m_busy        = 1'b1;
        widx          = 0;
        exp_flag_tick = cyc + 2;
        exp_flag_kind = 0;
        exp_clr_tick  = cyc + 1;
        exp_err_tick  = -1;
      end
    end
    if (req_stop) begin
      stop     = 1'b1;
      req_stop = 1'b0;
    end
    if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        bus.xfer_done = 1'b1;
        if (m_kind == 0) begin
          chk("writ_data_hold", bus.writ_data, m_word);
          widx++;
          if (widx == CFG_WORDS) begin
            exp_cfg_tick  = cyc + 1;
            exp_flag_tick = cyc + SAMPLE_GAP + 3;
            exp_flag_kind = 1;
          end else begin
            exp_flag_tick = cyc + 2;
            exp_flag_kind = 0;
          end
        end else begin
          bus.read_data = m_data;
          n_reads++;
          exp_sd_q.push_back(m_data[15:0]);
          exp_st_q.push_back(cyc + 2);
          if (stop_with_done) begin
            stop           = 1'b1;
            stop_with_done = 1'b0;
            m_busy         = 1'b0;
            exp_flag_tick  = -1;
          end else begin
            exp_flag_tick = cyc + SAMPLE_GAP + 3;
            exp_flag_kind = 1;
          end
        end
      end
    end else if (req_spur) begin
      bus.xfer_done = 1'b1;
      r             = $urandom;
      bus.read_data = r;
      req_spur      = 1'b0;
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog simulation did not complete cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    int          base;
    rst_n         = 1'b0;
    start         = 1'b0;
    stop          = 1'b0;
    bus.xfer_done = 1'b0;
    bus.read_data = 32'd0;
    force_q.push_back(32'hABCD_1234);
    r = $urandom;
    force_q.push_back({r[31:16], 16'hFFFF});
    r = $urandom;
    force_q.push_back({r[31:16], 16'h0000});

    repeat (3) tick();
    chk("rst_writ_flag", 32'(bus.writ_flag), 32'd0);
    chk("rst_read_flag", 32'(bus.read_flag), 32'd0);
    chk("rst_writ_data", bus.writ_data, 32'd0);
    chk("rst_sample_data", 32'(sample_data), 32'd0);
    chk("rst_sample_valid", 32'(sample_valid), 32'd0);
    chk("rst_cfg_done", 32'(cfg_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    tick();

    // start and stop together in IDLE: start must win
    req_start = 1'b1;
    req_stop  = 1'b1;
    tick();
    for (int i = 0; i < 8000 && n_samples < 5; i++) tick();
    chk("five_samples", 32'(n_samples >= 5), 32'd1);
    chk("busy_sampling", 32'(busy), 32'd1);
    chk("cfg_done_level", 32'(cfg_done), 32'd1);

    // stop coincident with a read completion
    stop_with_done = 1'b1;
    for (int i = 0; i < 3000 && (stop_with_done || exp_sd_q.size() > 0); i++) tick();
    chk("stop_sample_out", 32'(!stop_with_done && exp_sd_q.size() == 0), 32'd1);
    repeat (SAMPLE_GAP + 100) tick();
    chk("idle_after_stop_busy", 32'(busy), 32'd0);
    chk("idle_after_stop_err", 32'(err), 32'd0);
    chk("reads_vs_samples", 32'(n_samples), 32'(n_reads));

    // second config word never completes
    drop_at   = 1;
    req_start = 1'b1;
    tick();
    for (int i = 0; i < 500 && !(exp_err_tick > 0 && cyc > exp_err_tick); i++) tick();
    chk("timeout_reached", 32'(exp_err_tick > 0 && cyc > exp_err_tick), 32'd1);
    repeat (100) tick();
    chk("err_sticky", 32'(err), 32'd1);
    chk("busy_in_err", 32'(busy), 32'd0);

    // restart from ERR with ignored starts and a stray completion
    req_start = 1'b1;
    tick();
    for (int i = 0; i < 200 && !(widx == 1 && m_kind == 0 && m_cnt == 20); i++) tick();
    chk("reach_cfg_wait", 32'(widx == 1 && m_cnt == 20), 32'd1);
    req_start = 1'b1;
    tick();
    base = n_reads;
    for (int i = 0; i < 2000 && n_reads == base; i++) tick();
    chk("first_read_after_restart", 32'(n_reads > base), 32'd1);
    repeat (100) tick();
    req_spur = 1'b1;
    tick();
    for (int i = 0; i < 2000 && !(m_kind == 1 && m_cnt == 10); i++) tick();
    chk("reach_rd_wait", 32'(m_kind == 1 && m_cnt == 10), 32'd1);
    req_start = 1'b1;
    tick();
    base = n_samples;
    for (int i = 0; i < 4000 && n_samples < base + 2; i++) tick();
    chk("samples_after_disturb", 32'(n_samples >= base + 2), 32'd1);

    stop_with_done = 1'b1;
    for (int i = 0; i < 3000 && (stop_with_done || exp_sd_q.size() > 0); i++) tick();
    repeat (50) tick();
    chk("final_idle_busy", 32'(busy), 32'd0);
    chk("final_queue_empty", 32'(exp_sd_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
